// File: rtl/serial_rx16.sv
// Serial-in/parallel-out word receiver for the LSB-first load/shift link; data_valid/data_ack hold the word.
// Latency: start sampled at edge k, bit i sampled at edge k+1+i, word and data_valid registered at edge k+WIDTH.
// No backpressure on the link: a word completing while the previous one is unread overwrites it and sets overrun.
module serial_rx16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_error,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  // Bit 0 of the shift register is never stored: on the final bit it is taken
  // straight from the shifted value, so only the upper WIDTH-1 bits are kept.
  logic [WIDTH-1:1] sreg_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;

  logic [WIDTH-1:0] shifted_d;
  logic             done_d;
  logic             abort_d;

  // Shift-register next value and the frame events happening on this edge
  always_comb begin
    shifted_d = {serial_in, sreg_q[WIDTH-1:1]};
    done_d    = (state_q == RECV) && (cnt_q == LAST);
    abort_d   = (state_q == RECV) && (cnt_q != LAST) && start;
  end

  // Receive FSM, bit counter, word register and handshake/error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= abort_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RECV;
            cnt_q   <= '0;
          end
        end
        RECV: begin
          if (done_d) begin
            // A start on the last bit chains straight into the next frame.
            sreg_q  <= shifted_d[WIDTH-1:1];
            cnt_q   <= '0;
            state_q <= start ? RECV : IDLE;
          end else if (start) begin
            // Restart: the partial word is abandoned and this bit is dropped.
            cnt_q <= '0;
          end else begin
            sreg_q <= shifted_d[WIDTH-1:1];
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // A completing word wins over a same-edge ack, which then just hands over
      // the new word without counting as an overrun.
      if (done_d) begin
        data_q  <= shifted_d;
        valid_q <= 1'b1;
        if (valid_q && !data_ack) begin
          ovr_q <= 1'b1;
        end
      end else if (data_ack) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign busy        = (state_q == RECV);
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_serial_rx16.sv
// Bench for serial_rx16: frame table, hand-built corner sequences, then random traffic.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// The random phase compares against a frame-history model of the link.
module tb_serial_rx16;

  localparam int W  = 16;
  localparam int NR = 3000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         serial_in;
  logic         data_ack;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         frame_error;
  logic         overrun;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_rx16 #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .serial_in   (serial_in),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // One clock: drive inputs now (falling edge), return at the next falling edge.
  task automatic cyc(input logic s, input logic d, input logic a);
    start     = s;
    serial_in = d;
    data_ack  = a;
    @(negedge clk);
  endtask

  task automatic chk_all(input string name, input logic [W-1:0] d, input logic v,
                         input logic b, input logic fe, input logic ov);
    chk({name, ".data"},  32'(data_out),    32'(d));
    chk({name, ".valid"}, 32'(data_valid),  32'(v));
    chk({name, ".busy"},  32'(busy),        32'(b));
    chk({name, ".ferr"},  32'(frame_error), 32'(fe));
    chk({name, ".ovr"},   32'(overrun),     32'(ov));
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic         ack;
    logic [W-1:0] exp_data;
    logic         exp_v;
    logic         exp_ov;
    logic         exp_v_after;
    logic         exp_ov_after;
  } vec_t;

  vec_t tbl[6];
  logic hist[NR];

  initial begin
    logic         busy_ok;
    logic         hold_ok;
    logic         idle_busy;
    logic [W-1:0] prev_data;
    logic [W-1:0] w;
    logic [W-1:0] m_data;
    logic         m_v, m_ov, m_fe, comp, abrt, st, sd, ak;
    int           s;

    tbl[0] = '{16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h1234, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'h5A5A, 1'b0, 16'h5A5A, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{16'h8001, 1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset values, checked before any clock edge, then after a long idle stretch
    reset = 1'b1; start = 1'b0; serial_in = 1'b1; data_ack = 1'b0;
    #3;
    chk_all("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      idle_busy |= busy;
    end
    chk("idle_busy_seen", 32'(idle_busy), 32'd0);
    chk_all("idle40", '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame table: one frame per row, then one cycle with or without ack
    prev_data = '0;
    for (int r = 0; r < 6; r++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk($sformatf("row%0d.busy_start", r), 32'(busy), 32'd1);
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      for (int i = 0; i < W; i++) begin
        cyc(1'b0, tbl[r].word[i], 1'b0);
        if (i < W - 1) begin
          busy_ok &= busy;
          hold_ok &= (data_out == prev_data);
        end
      end
      chk($sformatf("row%0d.busy_frame", r), 32'(busy_ok), 32'd1);
      chk($sformatf("row%0d.hold_before_edge16", r), 32'(hold_ok), 32'd1);
      chk_all($sformatf("row%0d.done", r), tbl[r].exp_data, tbl[r].exp_v, 1'b0, 1'b0, tbl[r].exp_ov);
      cyc(1'b0, 1'b0, tbl[r].ack);
      chk_all($sformatf("row%0d.after", r), tbl[r].exp_data, tbl[r].exp_v_after, 1'b0, 1'b0,
              tbl[r].exp_ov_after);
      prev_data = tbl[r].exp_data;
    end

    // Back-to-back frames; the first word is acked on the cycle after it lands
    cyc(1'b1, 1'b1, 1'b0);
    busy_ok = busy;
    w = 16'h0001;
    for (int i = 0; i < W; i++) begin
      cyc(i == W - 1, w[i], 1'b0);
      busy_ok &= busy;
    end
    chk_all("b2b.first", 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    w = 16'h8000;
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, w[i], i == 0);
      if (i == 0) chk("b2b.ack_clears", 32'(data_valid), 32'd0);
      if (i < W - 1) busy_ok &= busy;
    end
    chk("b2b.busy_continuous", 32'(busy_ok), 32'd1);
    chk_all("b2b.second", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("b2b.ack2", 32'(data_valid), 32'd0);

    // Abort: restart at edge 7, then the bits of 0x00FF on edges 8..23
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("abort.no_ferr_yet", 32'(frame_error), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("abort.ferr_pulse", 32'(frame_error), 32'd1);
    chk("abort.busy", 32'(busy), 32'd1);
    w = 16'h00FF;
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, w[i], 1'b0);
      if (i == 0) chk("abort.ferr_one_cycle", 32'(frame_error), 32'd0);
      if (i == 8) begin
        chk("abort.no_word_edge16", 32'(data_valid), 32'd0);
        chk("abort.data_held_edge16", 32'(data_out), 32'h8000);
      end
    end
    chk_all("abort.word_edge23", 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset 5 cycles into a frame, with an unread word still held
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_all("midreset.async", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
    chk_all("midreset.needs_start", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    w = 16'h5A5A;
    for (int i = 0; i < W; i++) cyc(1'b0, w[i], 1'b0);
    chk_all("midreset.next_frame", 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic against a model built from the input history:
    // a frame started at edge s completes at edge s+W unless restarted earlier,
    // and its word is the bits sampled at edges s+1..s+W, LSB first.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    s = -1; m_data = '0; m_v = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
    for (int n = 0; n < NR; n++) begin
      st = ($urandom_range(0, 19) == 0);
      sd = 1'($urandom_range(0, 1));
      ak = ($urandom_range(0, 3) == 0);
      hist[n] = sd;
      comp = (s >= 0) && (n == s + W);
      abrt = (s >= 0) && !comp && st;
      if (comp) begin
        for (int i = 0; i < W; i++) w[i] = hist[s + 1 + i];
        m_data = w;
        m_ov   = m_ov | (m_v & ~ak);
        m_v    = 1'b1;
      end else if (ak && m_v) begin
        m_v  = 1'b0;
        m_ov = 1'b0;
      end
      m_fe = abrt;
      if (st) s = n;
      else if (comp) s = -1;
      cyc(st, sd, ak);
      chk_all($sformatf("rand%0d", n), m_data, m_v, s >= 0, m_fe, m_ov);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
